// File: rtl/morty_pipeline_ctrl.sv
// Morty 5-stage pipeline sequencer: turns hazard, branch and memory-busy inputs into
// per-stage stall/flush controls and runs the exception drain -> trap -> recover sequence.
module morty_pipeline_ctrl #(
    parameter int unsigned DRAIN_MAX = 15,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_stall_req_i,
    input  logic             csr_stall_req_i,
    input  logic             illegal_stall_req_i,
    input  logic             xcall_break_stall_req_i,
    input  logic             mem_exc_i,
    input  logic             mem_busy_i,
    input  logic             branch_taken_i,
    output logic             if_stall_o,
    output logic             id_stall_o,
    output logic             ex_stall_o,
    output logic             mem_stall_o,
    output logic             if_flush_o,
    output logic             id_flush_o,
    output logic             ex_flush_o,
    output logic             mem_flush_o,
    output logic             trap_o,
    output logic             drain_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {RUN, DRAIN, TRAP, RECOVER} state_t;

    // Counter value seen in the last permitted DRAIN cycle before a forced trap.
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

    state_t           state_q, state_d;
    logic [7:0]       drain_cnt_q, drain_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        timeout_d   = timeout_q;
        if_stall_o  = 1'b0;
        id_stall_o  = 1'b0;
        ex_stall_o  = 1'b0;
        mem_stall_o = 1'b0;
        if_flush_o  = 1'b0;
        id_flush_o  = 1'b0;
        ex_flush_o  = 1'b0;
        mem_flush_o = 1'b0;
        trap_o      = 1'b0;

        if (rst_i) begin
            if_flush_o  = 1'b1;
            id_flush_o  = 1'b1;
            ex_flush_o  = 1'b1;
            mem_flush_o = 1'b1;
        end else if (mem_busy_i) begin
            // Whole-pipe freeze; FSM and drain counter hold their values.
            if_stall_o  = 1'b1;
            id_stall_o  = 1'b1;
            ex_stall_o  = 1'b1;
            mem_stall_o = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken_i) begin
                        // Younger requests are wrong-path; EX/MEM ones re-assert next cycle.
                        if_flush_o = 1'b1;
                        id_flush_o = 1'b1;
                    end else if (illegal_stall_req_i || xcall_break_stall_req_i) begin
                        state_d    = DRAIN;
                        if_stall_o = 1'b1;
                        id_flush_o = 1'b1;
                    end else if (ld_stall_req_i || csr_stall_req_i) begin
                        if_stall_o = 1'b1;
                        id_stall_o = 1'b1;
                        ex_flush_o = 1'b1;
                    end
                end
                DRAIN: begin
                    if_stall_o  = 1'b1;
                    id_flush_o  = 1'b1;
                    drain_cnt_d = drain_cnt_q + 8'd1;
                    if (mem_exc_i) begin
                        state_d = TRAP;
                    end else if (drain_cnt_q >= DRAIN_LAST) begin
                        state_d   = TRAP;
                        timeout_d = 1'b1;
                    end
                end
                TRAP: begin
                    trap_o      = 1'b1;
                    if_flush_o  = 1'b1;
                    id_flush_o  = 1'b1;
                    ex_flush_o  = 1'b1;
                    mem_flush_o = 1'b1;
                    drain_cnt_d = 8'd0;
                    state_d     = RECOVER;
                end
                RECOVER: begin
                    // Discard the fetch issued before the PC was redirected.
                    if_flush_o = 1'b1;
                    state_d    = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            drain_cnt_q <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            timeout_q   <= timeout_d;
            if (if_stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign drain_timeout_o = timeout_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_morty_pipeline_ctrl.sv
// Directed bench for morty_pipeline_ctrl (DRAIN_MAX=4, CNT_W=4): hazards, branch, drain,
// timeout, freeze, counter saturation and reset during TRAP.
module tb_morty_pipeline_ctrl;

    localparam int unsigned DRAIN_MAX = 4;
    localparam int unsigned CNT_W     = 4;

    logic clk = 1'b0;
    logic rst_i, ld_stall_req_i, csr_stall_req_i, illegal_stall_req_i;
    logic xcall_break_stall_req_i, mem_exc_i, mem_busy_i, branch_taken_i;
    logic if_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
    logic if_flush_o, id_flush_o, ex_flush_o, mem_flush_o;
    logic trap_o, drain_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    morty_pipeline_ctrl #(.DRAIN_MAX(DRAIN_MAX), .CNT_W(CNT_W)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst_i),
        .ld_stall_req_i          (ld_stall_req_i),
        .csr_stall_req_i         (csr_stall_req_i),
        .illegal_stall_req_i     (illegal_stall_req_i),
        .xcall_break_stall_req_i (xcall_break_stall_req_i),
        .mem_exc_i               (mem_exc_i),
        .mem_busy_i              (mem_busy_i),
        .branch_taken_i          (branch_taken_i),
        .if_stall_o              (if_stall_o),
        .id_stall_o              (id_stall_o),
        .ex_stall_o              (ex_stall_o),
        .mem_stall_o             (mem_stall_o),
        .if_flush_o              (if_flush_o),
        .id_flush_o              (id_flush_o),
        .ex_flush_o              (ex_flush_o),
        .mem_flush_o             (mem_flush_o),
        .trap_o                  (trap_o),
        .drain_timeout_o         (drain_timeout_o),
        .stall_cnt_o             (stall_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controls packed as {stall[if,id,ex,mem], flush[if,id,ex,mem], trap}.
    task automatic check_ctl(input string tag, input logic [3:0] st, input logic [3:0] fl,
                             input logic tr);
        check(tag, {23'd0, if_stall_o, id_stall_o, ex_stall_o, mem_stall_o,
                    if_flush_o, id_flush_o, ex_flush_o, mem_flush_o, trap_o},
              {23'd0, st, fl, tr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_i = 1'b1; ld_stall_req_i = 1'b0; csr_stall_req_i = 1'b0;
        illegal_stall_req_i = 1'b0; xcall_break_stall_req_i = 1'b0;
        mem_exc_i = 1'b0; mem_busy_i = 1'b0; branch_taken_i = 1'b0;
        tick();
        tick();

        // Reset state
        check_ctl("reset_ctl", 4'b0000, 4'b1111, 1'b0);
        check("reset_cnt", 32'(stall_cnt_o), 32'd0);
        check("reset_tmo", 32'(drain_timeout_o), 32'd0);
        rst_i = 1'b0;
        #1 check_ctl("idle", 4'b0000, 4'b0000, 1'b0);
        tick();

        // Load-use for one cycle
        ld_stall_req_i = 1'b1;
        #1 check_ctl("load_use", 4'b1100, 4'b0010, 1'b0);
        tick();
        ld_stall_req_i = 1'b0;
        #1 check_ctl("load_done", 4'b0000, 4'b0000, 1'b0);
        check("load_cnt", 32'(stall_cnt_o), 32'd1);

        // CSR stall behaves like a load stall
        csr_stall_req_i = 1'b1;
        #1 check_ctl("csr_stall", 4'b1100, 4'b0010, 1'b0);
        tick();
        csr_stall_req_i = 1'b0;

        // Branch wins over load, then over ecall; FSM stays in RUN
        branch_taken_i = 1'b1; ld_stall_req_i = 1'b1;
        #1 check_ctl("branch_ld", 4'b0000, 4'b1100, 1'b0);
        tick();
        ld_stall_req_i = 1'b0; xcall_break_stall_req_i = 1'b1;
        #1 check_ctl("branch_xcall", 4'b0000, 4'b1100, 1'b0);
        tick();
        branch_taken_i = 1'b0; xcall_break_stall_req_i = 1'b0;
        #1 check_ctl("after_branch", 4'b0000, 4'b0000, 1'b0);
        check("branch_cnt", 32'(stall_cnt_o), 32'd2);

        // ecall drain, mem_exc two cycles after the request
        xcall_break_stall_req_i = 1'b1;
        #1 check_ctl("ecall_req", 4'b1000, 4'b0100, 1'b0);
        tick();
        xcall_break_stall_req_i = 1'b0;
        #1 check_ctl("ecall_drain1", 4'b1000, 4'b0100, 1'b0);
        tick();
        mem_exc_i = 1'b1;
        #1 check_ctl("ecall_drain2", 4'b1000, 4'b0100, 1'b0);
        tick();
        mem_exc_i = 1'b0;
        #1 check_ctl("ecall_trap", 4'b0000, 4'b1111, 1'b1);
        tick();
        check_ctl("ecall_recover", 4'b0000, 4'b1000, 1'b0);
        tick();
        check_ctl("ecall_run", 4'b0000, 4'b0000, 1'b0);
        check("ecall_tmo", 32'(drain_timeout_o), 32'd0);
        check("ecall_cnt", 32'(stall_cnt_o), 32'd5);

        // Timeout: illegal held, no mem_exc; branch during DRAIN is ignored
        illegal_stall_req_i = 1'b1;
        #1 check_ctl("tmo_req", 4'b1000, 4'b0100, 1'b0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            branch_taken_i = (i == 2);
            #1 check_ctl($sformatf("tmo_drain%0d", i), 4'b1000, 4'b0100, 1'b0);
            check($sformatf("tmo_flag_pre%0d", i), 32'(drain_timeout_o), 32'd0);
            tick();
        end
        branch_taken_i = 1'b0;
        check_ctl("tmo_trap", 4'b0000, 4'b1111, 1'b1);
        check("tmo_flag", 32'(drain_timeout_o), 32'd1);
        tick();
        illegal_stall_req_i = 1'b0;
        #1 check_ctl("tmo_recover", 4'b0000, 4'b1000, 1'b0);
        tick();
        check_ctl("tmo_run", 4'b0000, 4'b0000, 1'b0);
        check("tmo_sticky", 32'(drain_timeout_o), 32'd1);
        check("tmo_cnt", 32'(stall_cnt_o), 32'd10);

        // Freeze mid-DRAIN: count 1 before freeze, 3 more DRAIN cycles after
        xcall_break_stall_req_i = 1'b1;
        tick();
        xcall_break_stall_req_i = 1'b0;
        #1 check_ctl("frz_drain1", 4'b1000, 4'b0100, 1'b0);
        tick();
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check_ctl($sformatf("frz_busy%0d", i), 4'b1111, 4'b0000, 1'b0);
            tick();
        end
        mem_busy_i = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            #1 check_ctl($sformatf("frz_drain%0d", i), 4'b1000, 4'b0100, 1'b0);
            tick();
        end
        check_ctl("frz_trap", 4'b0000, 4'b1111, 1'b1);
        check("frz_sat", 32'(stall_cnt_o), 32'd15);

        // Reset asserted during TRAP
        rst_i = 1'b1;
        #1 check_ctl("rst_in_trap", 4'b0000, 4'b1111, 1'b0);
        tick();
        check_ctl("rst_hold", 4'b0000, 4'b1111, 1'b0);
        check("rst_cnt", 32'(stall_cnt_o), 32'd0);
        check("rst_tmo", 32'(drain_timeout_o), 32'd0);
        rst_i = 1'b0;
        #1 check_ctl("rst_run", 4'b0000, 4'b0000, 1'b0);
        tick();
        check_ctl("rst_no_recover", 4'b0000, 4'b0000, 1'b0);

        // Saturation: 20 cycles of load stall with a 4-bit counter
        ld_stall_req_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 15) check("sat_reach", 32'(stall_cnt_o), 32'd15);
            tick();
        end
        ld_stall_req_i = 1'b0;
        #1 check("sat_final", 32'(stall_cnt_o), 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/morty_pipeline_ctrl.md
# morty_pipeline_ctrl

Pipeline sequencer for the Morty 5-stage core: converts the hazard unit's stall requests (load, CSR, illegal, ecall/ebreak), the taken-branch signal and the data-memory busy signal into per-stage stall/flush controls and the trap-redirect pulse. It sits between the hazard unit and the IF/ID/EX/MEM pipeline registers and PC mux. It owns the exception drain sequence: stop fetch, let older instructions retire, redirect to the trap vector, then discard the in-flight fetch.

## Interface
- DRAIN_MAX, default 15: maximum DRAIN cycles before a forced trap; range 1..255.
- CNT_W, default 16: width of the stall-cycle counter.

- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-high reset.
- ld_stall_req_i  in  1  load-use hazard request from the hazard unit.
- csr_stall_req_i  in  1  CSR hazard request.
- illegal_stall_req_i  in  1  illegal instruction present in ID, EX or MEM.
- xcall_break_stall_req_i  in  1  ecall/ebreak present in ID, EX or MEM.
- mem_exc_i  in  1  excepting instruction is in MEM; all older instructions have retired.
- mem_busy_i  in  1  data memory has not acknowledged; freeze the pipeline.
- branch_taken_i  in  1  branch/jump resolved taken in EX.
- if_stall_o, id_stall_o, ex_stall_o, mem_stall_o  out  1 each  hold the stage register.
- if_flush_o, id_flush_o, ex_flush_o, mem_flush_o  out  1 each  load a bubble into the stage register.
- trap_o  out  1  one-cycle pulse: PC mux selects the trap vector; CSR unit latches the cause.
- drain_timeout_o  out  1  registered sticky flag: a trap was forced by the DRAIN_MAX timeout.
- stall_cnt_o  out  CNT_W  saturating count of cycles with if_stall_o=1.

## Operation
- FSM states are RUN, DRAIN, TRAP and RECOVER. The reset state is RUN.
- During rst_i: all four flush outputs are 1, all stalls are 0, trap_o is 0, and the drain counter, drain_timeout_o and stall_cnt_o are cleared.
- Priority in every state: mem_busy_i forces all four stalls to 1 and all flushes and trap_o to 0. The FSM and drain counter hold.
- RUN:
  - If branch_taken_i=1: if_flush_o=id_flush_o=1, no stall, and the FSM stays in RUN. Load, CSR and exception requests are ignored this cycle because younger instructions are wrong-path; EX/MEM requests re-assert next cycle.
  - Else if illegal_stall_req_i or xcall_break_stall_req_i: go to DRAIN, with if_stall_o=1 and id_flush_o=1.
  - Else if ld_stall_req_i or csr_stall_req_i: if_stall_o=id_stall_o=1 and ex_flush_o=1 (bubble into EX). The FSM stays in RUN.
  - Else all controls are 0.
- DRAIN:
  - if_stall_o=1 and id_flush_o=1; EX/MEM advance.
  - The drain counter increments each non-frozen cycle.
  - If mem_exc_i=1, go to TRAP.
  - Else, when the counter reaches DRAIN_MAX, go to TRAP and set drain_timeout_o.
  - branch_taken_i is ignored in DRAIN.
- TRAP (one cycle): trap_o=1 and all four flushes are 1. The drain counter clears. Next state is RECOVER.
- RECOVER (one cycle): if_flush_o=1 to discard the fetch issued before the redirect. Next state is RUN.
- drain_timeout_o clears only on reset.
- stall_cnt_o increments on every cycle with if_stall_o=1, including mem_busy_i cycles. It saturates at 2^CNT_W−1 and does not wrap.

## Timing
- All stall, flush and trap outputs are combinational from the state and inputs; the FSM registers update on the rising clk_i edge.
- Exception latency is at least 3 cycles from the first request cycle to the first fetch at the trap vector: DRAIN (≥1), TRAP, RECOVER.
- Load/CSR stalls add zero-latency bubbles, one per cycle that the request is held.
- A reset asserted mid-DRAIN or mid-TRAP returns the FSM to RUN on the next edge and suppresses trap_o in that cycle.
- A request arriving while the FSM is in TRAP or RECOVER is not sampled; it is evaluated on return to RUN.

## Test plan
- Load-use: ld_stall_req_i=1 for 1 cycle in RUN gives if_stall_o=id_stall_o=ex_flush_o=1 that cycle, then zero; stall_cnt_o rises from 0 to 1.
- Branch versus load: branch_taken_i=1 and ld_stall_req_i=1 together give if_flush_o=id_flush_o=1, no stalls, and the FSM stays in RUN.
- ecall drain: xcall_break_stall_req_i=1, then mem_exc_i=1 two cycles later.
  - Sequence: DRAIN, DRAIN, TRAP (trap_o=1, all flushes=1), RECOVER (if_flush_o=1), RUN.
  - drain_timeout_o stays 0.
- Timeout: DRAIN_MAX=4, illegal_stall_req_i=1 and mem_exc_i held 0 give trap_o=1 exactly 4 DRAIN cycles later, with drain_timeout_o=1 and held until reset.
- Freeze: mem_busy_i=1 for 3 cycles mid-DRAIN sets all stalls to 1, with no state or counter change; the drain then resumes with the same count.
- Saturation and reset: with CNT_W=4, holding a load stall 20 cycles leaves stall_cnt_o=15. Asserting rst_i during TRAP clears the count and all flushes are 1 while rst_i is high.
